dcache_2way_top: RTL and testbench

//  2-way set-associative, write-back, write-allocate data cache between the CPU

---
 rtl/dcache_pkg.sv | 32 +++
 rtl/dcache_way_sram.sv | 30 +++
 rtl/dcache_2way_top.sv | 150 +++++++++++++++
 tb/tb_dcache_2way_top.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared definitions for the 2-way data cache: FSM encoding, geometry
// derivation and the replacement-victim rule.
package dcache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WRITEBACK,
    S_REFILL,
    S_REFILL_DONE
  } state_t;

  function automatic int calc_index_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int calc_offset_w(input int line_bytes);
    return $clog2(line_bytes);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int num_sets, input int line_bytes);
    return addr_w - $clog2(num_sets) - $clog2(line_bytes);
  endfunction

  // An empty way is always preferred (way0 first); LRU only decides a full set.
  function automatic logic pick_victim(input logic valid0, input logic valid1, input logic lru);
    if (!valid0) return 1'b0;
    if (!valid1) return 1'b1;
    return lru;
  endfunction

endpackage

// File: rtl/dcache_way_sram.sv
// One way of the cache: tag and line storage, combinational read,
// synchronous write, no reset (contents are qualified by the valid flops).
module dcache_way_sram #(
  parameter int TAG_W    = 22,
  parameter int LINE_W   = 256,
  parameter int NUM_SETS = 32
) (
  input  logic                        clk_i,
  input  logic [$clog2(NUM_SETS)-1:0] addr_i,
  input  logic [TAG_W-1:0]            tag_i,
  input  logic [LINE_W-1:0]           data_i,
  input  logic                        write_i,
  output logic [TAG_W-1:0]            tag_o,
  output logic [LINE_W-1:0]           data_o
);

  logic [TAG_W-1:0]  tag_mem  [NUM_SETS];
  logic [LINE_W-1:0] data_mem [NUM_SETS];

  always_ff @(posedge clk_i) begin
    if (write_i) begin
      tag_mem[addr_i]  <= tag_i;
      data_mem[addr_i] <= data_i;
    end
  end

  assign tag_o  = tag_mem[addr_i];
  assign data_o = data_mem[addr_i];

endmodule

// File: rtl/dcache_2way_top.sv
// 2-way set-associative write-back/write-allocate data cache with per-set LRU.
// Valid/dirty/LRU live in flops; tags and lines live in two dcache_way_sram.
module dcache_2way_top
  import dcache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int NUM_SETS   = 32,
  parameter int LINE_BYTES = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [8*LINE_BYTES-1:0] mem_data_i,
  input  logic                    mem_ack_i,
  output logic [8*LINE_BYTES-1:0] mem_data_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic                    mem_enable_o,
  output logic                    mem_write_o,
  input  logic [31:0]             p1_data_i,
  input  logic [ADDR_W-1:0]       p1_addr_i,
  input  logic                    p1_MemRead_i,
  input  logic                    p1_MemWrite_i,
  output logic [31:0]             p1_data_o,
  output logic                    p1_stall_o,
  output state_t                  dbg_state_o
);

  localparam int INDEX_W  = calc_index_w(NUM_SETS);
  localparam int OFFSET_W = calc_offset_w(LINE_BYTES);
  localparam int TAG_W    = calc_tag_w(ADDR_W, NUM_SETS, LINE_BYTES);
  localparam int LINE_W   = 8 * LINE_BYTES;
  localparam int WSEL_W   = OFFSET_W - 2;

  state_t              state, state_next;
  logic [TAG_W-1:0]    miss_tag;
  logic [INDEX_W-1:0]  miss_idx;
  logic                victim;
  logic [1:0][NUM_SETS-1:0] valid, dirty;
  logic [NUM_SETS-1:0] lru;

  logic [TAG_W-1:0]    p_tag;
  logic [INDEX_W-1:0]  p_idx;
  logic [WSEL_W-1:0]   p_word;
  logic                req, hit_any, hit_way, store_hit, refill_fire, miss_start;
  logic [1:0]          way_match, wr_en;
  logic [INDEX_W-1:0]  sram_idx;
  logic [TAG_W-1:0]    wr_tag;
  logic [LINE_W-1:0]   wr_line, hit_line, merged;
  logic [TAG_W-1:0]    tag_rd  [2];
  logic [LINE_W-1:0]   line_rd [2];
  logic                unused_addr_bits;

  assign req              = p1_MemRead_i | p1_MemWrite_i;
  assign p_tag            = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign p_idx            = p1_addr_i[OFFSET_W +: INDEX_W];
  assign p_word           = p1_addr_i[2 +: WSEL_W];
  assign unused_addr_bits = ^p1_addr_i[1:0];

  // While a miss is in flight the SRAMs are addressed only from miss_idx.
  assign sram_idx = (state inside {S_MISS, S_WRITEBACK, S_REFILL}) ? miss_idx : p_idx;

  for (genvar w = 0; w < 2; w++) begin : g_way
    dcache_way_sram #(.TAG_W(TAG_W), .LINE_W(LINE_W), .NUM_SETS(NUM_SETS)) u_sram (
      .clk_i   (clk_i),
      .addr_i  (sram_idx),
      .tag_i   (wr_tag),
      .data_i  (wr_line),
      .write_i (wr_en[w]),
      .tag_o   (tag_rd[w]),
      .data_o  (line_rd[w])
    );
    assign way_match[w] = valid[w][p_idx] && (tag_rd[w] == p_tag);
  end

  // Way0 wins if both ways ever match.
  assign hit_way     = ~way_match[0];
  assign hit_any     = (state == S_IDLE) && req && (|way_match);
  assign store_hit   = hit_any && p1_MemWrite_i;
  assign refill_fire = (state == S_REFILL) && mem_ack_i;
  assign miss_start  = (state == S_IDLE) && req && !hit_any;
  assign hit_line    = line_rd[hit_way];
  assign p1_data_o   = hit_any ? hit_line[{p_word, 5'b00000} +: 32] : 32'h0;
  assign p1_stall_o  = req & ~hit_any;
  assign dbg_state_o = state;
  assign mem_data_o  = line_rd[victim];

  always_comb begin
    merged = hit_line;
    merged[{p_word, 5'b00000} +: 32] = p1_data_i;
    wr_line  = refill_fire ? mem_data_i : merged;
    wr_tag   = refill_fire ? miss_tag : p_tag;
    wr_en[0] = (store_hit && !hit_way) || (refill_fire && !victim);
    wr_en[1] = (store_hit &&  hit_way) || (refill_fire &&  victim);
  end

  // Memory handshake: mem_enable_o/mem_write_o/mem_addr_o/mem_data_o are held
  // stable while enable is high; the transfer completes on the cycle mem_ack_i is 1.
  always_comb begin
    state_next   = state;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = {miss_tag, miss_idx, {OFFSET_W{1'b0}}};
    unique case (state)
      S_IDLE:        if (miss_start) state_next = S_MISS;
      S_MISS:        state_next = (valid[victim][miss_idx] && dirty[victim][miss_idx])
                                  ? S_WRITEBACK : S_REFILL;
      S_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_rd[victim], miss_idx, {OFFSET_W{1'b0}}};
        if (mem_ack_i) state_next = S_REFILL;
      end
      S_REFILL: begin
        mem_enable_o = 1'b1;
        if (mem_ack_i) state_next = S_REFILL_DONE;
      end
      S_REFILL_DONE: state_next = S_IDLE;
      default:       state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state    <= S_IDLE;
      miss_tag <= '0;
      miss_idx <= '0;
      victim   <= 1'b0;
      valid    <= '0;
      dirty    <= '0;
      lru      <= '0;
    end else begin
      state <= state_next;
      if (miss_start) begin
        miss_tag <= p_tag;
        miss_idx <= p_idx;
        victim   <= pick_victim(valid[0][p_idx], valid[1][p_idx], lru[p_idx]);
      end
      if (hit_any) begin
        lru[p_idx] <= ~hit_way;
        if (p1_MemWrite_i) dirty[hit_way][p_idx] <= 1'b1;
        assert (!(way_match[0] && way_match[1]));
      end
      if (refill_fire) begin
        valid[victim][miss_idx] <= 1'b1;
        dirty[victim][miss_idx] <= 1'b0;
        lru[miss_idx]           <= ~victim;
      end
    end
  end

endmodule

// File: tb/tb_dcache_2way_top.sv
// Directed bench for dcache_2way_top: default geometry plus a 64-set/64-byte build.
module tb_dcache_2way_top;
  import dcache_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // DUT A: default parameters
  logic [255:0] a_mem_rdata, a_mem_wdata;
  logic [31:0]  a_maddr, a_wdata, a_addr, a_rdata;
  logic         a_ack, a_en, a_we, a_rd, a_wr, a_stall;
  state_t       a_state;

  // DUT B: 64 sets, 64-byte lines
  logic [511:0] b_mem_rdata, b_mem_wdata, b_line;
  logic [31:0]  b_maddr, b_wdata, b_addr, b_rdata;
  logic         b_ack, b_en, b_we, b_rd, b_wr, b_stall;
  state_t       b_state;

  dcache_2way_top u_dut_a (
    .clk_i(clk), .rst_i(rst_n), .mem_data_i(a_mem_rdata), .mem_ack_i(a_ack),
    .mem_data_o(a_mem_wdata), .mem_addr_o(a_maddr), .mem_enable_o(a_en), .mem_write_o(a_we),
    .p1_data_i(a_wdata), .p1_addr_i(a_addr), .p1_MemRead_i(a_rd), .p1_MemWrite_i(a_wr),
    .p1_data_o(a_rdata), .p1_stall_o(a_stall), .dbg_state_o(a_state)
  );

  dcache_2way_top #(.ADDR_W(32), .NUM_SETS(64), .LINE_BYTES(64)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n), .mem_data_i(b_mem_rdata), .mem_ack_i(b_ack),
    .mem_data_o(b_mem_wdata), .mem_addr_o(b_maddr), .mem_enable_o(b_en), .mem_write_o(b_we),
    .p1_data_i(b_wdata), .p1_addr_i(b_addr), .p1_MemRead_i(b_rd), .p1_MemWrite_i(b_wr),
    .p1_data_o(b_rdata), .p1_stall_o(b_stall), .dbg_state_o(b_state)
  );

  // scoreboard and bookkeeping
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int a_lat    = 3;
  int ack_cyc  = 0;
  int done_cyc = 0;

  typedef struct {
    logic         we;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;
  txn_t txn_log[$];

  logic [255:0] wb_mem  [logic [31:0]];
  logic [31:0]  ref_mem [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h400) return 32'h1111_1111;
    return {8'h5A, a[23:0]};
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] la);
    logic [255:0] l;
    if (wb_mem.exists(la)) return wb_mem[la];
    for (int k = 0; k < 8; k++) l[32*k +: 32] = init_word(la + 32'(4*k));
    return l;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic check_txn(input string tag, input int idx, input logic we, input logic [31:0] addr);
    if (idx < txn_log.size()) begin
      check({tag, "/we"}, 64'(txn_log[idx].we), 64'(we));
      check({tag, "/addr"}, 64'(txn_log[idx].addr), 64'(addr));
    end else begin
      check({tag, "/present"}, 64'(txn_log.size()), 64'(idx + 1));
    end
  endtask

  // memory model for DUT A
  initial begin
    txn_t t;
    a_ack = 1'b0;
    a_mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (a_en) begin
        t.we = a_we; t.addr = a_maddr; t.data = a_mem_wdata;
        repeat (a_lat - 1) @(negedge clk);
        if (t.we) wb_mem[t.addr] = t.data;
        else a_mem_rdata = mem_line(t.addr);
        txn_log.push_back(t);
        a_ack = 1'b1;
        ack_cyc = cyc;
        @(negedge clk);
        a_ack = 1'b0;
      end
    end
  end

  // driver: one CPU access on DUT A, held until the stall releases
  task automatic access(input string tag, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output int stalls);
    a_addr = addr; a_wdata = wdata; a_rd = !wr; a_wr = wr;
    if (!wr) exp_q.push_back(ref_read(addr));
    stalls = 0;
    #1;
    if (a_stall && !wr) check({tag, "/rdata_zero_on_miss"}, 64'(a_rdata), 64'h0);
    while (a_stall && stalls < 300) begin
      @(negedge clk); #1;
      stalls++;
    end
    done_cyc = cyc;
    check({tag, "/stall_released"}, 64'(a_stall), 64'h0);
    if (!wr) check({tag, "/rdata"}, 64'(a_rdata), 64'(exp_q.pop_front()));
    else ref_mem[{addr[31:2], 2'b00}] = wdata;
    @(negedge clk);
    a_rd = 1'b0; a_wr = 1'b0;
  endtask

  initial begin
    int st, n;
    rst_n = 1'b0;
    a_rd = 0; a_wr = 0; a_addr = '0; a_wdata = '0;
    b_rd = 0; b_wr = 0; b_addr = '0; b_wdata = '0; b_ack = 0; b_mem_rdata = '0; b_line = '0;
    repeat (3) @(negedge clk);
    check("reset/enable", 64'(a_en), 64'h0);
    check("reset/write", 64'(a_we), 64'h0);
    check("reset/state", 64'(a_state), 64'(S_IDLE));
    check("reset/stall", 64'(a_stall), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // cold load, slow memory
    a_lat = 10; txn_log.delete();
    access("t1_cold", 0, 32'h400, 0, st);
    check("t1_txn_count", 64'(txn_log.size()), 64'd1);
    check_txn("t1_txn0", 0, 1'b0, 32'h400);
    check("t1_stall_after_ack", 64'(done_cyc - ack_cyc), 64'd2);

    // fill the other way of set 0, then repeat hits with no traffic
    a_lat = $urandom_range(1, 4); txn_log.delete();
    access("t2_load0", 0, 32'h000, 0, st);
    check_txn("t2_txn0", 0, 1'b0, 32'h000);
    txn_log.delete();
    access("t2_hit400", 0, 32'h400, 0, st);
    check("t2_hit400_nostall", 64'(st), 64'd0);
    access("t2_hit000", 0, 32'h000, 0, st);
    check("t2_hit000_nostall", 64'(st), 64'd0);
    access("t2_hit41c", 0, 32'h41C, 0, st);
    check("t2_hit41c_nostall", 64'(st), 64'd0);
    check("t2_no_traffic", 64'(txn_log.size()), 64'd0);

    // LRU eviction: 0x400 is least recent, 0x800 replaces it cleanly
    access("t3_touch000", 0, 32'h000, 0, st);
    txn_log.delete();
    access("t3_load800", 0, 32'h800, 0, st);
    check("t3_missed", 64'(st != 0), 64'd1);
    check("t3_txn_count", 64'(txn_log.size()), 64'd1);
    check_txn("t3_txn0", 0, 1'b0, 32'h800);
    access("t3_hit000", 0, 32'h000, 0, st);
    check("t3_hit000_nostall", 64'(st), 64'd0);

    // dirty eviction
    access("t4_store004", 1, 32'h004, 32'hDEAD_BEEF, st);
    check("t4_store_hit", 64'(st), 64'd0);
    txn_log.delete();
    access("t4_load400", 0, 32'h400, 0, st);
    check("t4_400_txn_count", 64'(txn_log.size()), 64'd1);
    check_txn("t4_400_txn0", 0, 1'b0, 32'h400);
    txn_log.delete();
    access("t4_load800", 0, 32'h800, 0, st);
    check("t4_800_txn_count", 64'(txn_log.size()), 64'd2);
    check_txn("t4_wb", 0, 1'b1, 32'h000);
    if (txn_log.size() > 0) begin
      check("t4_wb_word1", 64'(txn_log[0].data[63:32]), 64'hDEAD_BEEF);
      check("t4_wb_word0", 64'(txn_log[0].data[31:0]), 64'(init_word(32'h0)));
    end
    check_txn("t4_refill800", 1, 1'b0, 32'h800);
    txn_log.delete();
    access("t4_loadc00", 0, 32'hC00, 0, st);
    check("t4_c00_txn_count", 64'(txn_log.size()), 64'd1);
    check_txn("t4_c00_txn0", 0, 1'b0, 32'hC00);
    access("t4_reload004", 0, 32'h004, 0, st);
    check("t4_reload_missed", 64'(st != 0), 64'd1);

    // store miss: write-allocate then merge
    access("t4_store_miss", 1, 32'h1028, 32'hCAFE_F00D, st);
    check("t4_store_miss_stalled", 64'(st != 0), 64'd1);
    access("t4_load1028", 0, 32'h1028, 0, st);
    access("t4_load102c", 0, 32'h102C, 0, st);
    check("t4_load102c_nostall", 64'(st), 64'd0);

    // reset while REFILL waits for ack; the ack then arrives in IDLE
    a_lat = 8; txn_log.delete();
    a_addr = 32'h2044; a_rd = 1'b1;
    n = 0;
    while (!a_en && n < 50) begin @(negedge clk); n++; end
    check("t5_enable_seen", 64'(a_en), 64'h1);
    repeat (2) @(negedge clk);
    check("t5_in_refill", 64'(a_state), 64'(S_REFILL));
    rst_n = 1'b0;
    #1;
    check("t5_enable_drop", 64'(a_en), 64'h0);
    check("t5_state_reset", 64'(a_state), 64'(S_IDLE));
    a_rd = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("t5_late_ack_ignored_en", 64'(a_en), 64'h0);
    check("t5_late_ack_ignored_state", 64'(a_state), 64'(S_IDLE));
    a_lat = 2; txn_log.delete();
    access("t5_reload", 0, 32'h2044, 0, st);
    check("t5_reload_missed", 64'(st != 0), 64'd1);
    check_txn("t5_reload_txn", 0, 1'b0, 32'h2040);
    access("t5_invalidated", 0, 32'h004, 0, st);
    check("t5_invalidated_missed", 64'(st != 0), 64'd1);

    // wider geometry: last set, last word
    b_addr = 32'h1_0FFC; b_rd = 1'b1;
    n = 0;
    while (!b_en && n < 50) begin @(negedge clk); n++; end
    check("t6_enable", 64'(b_en), 64'h1);
    check("t6_addr", 64'(b_maddr), 64'h1_0FC0);
    check("t6_write", 64'(b_we), 64'h0);
    check("t6_stall", 64'(b_stall), 64'h1);
    for (int k = 0; k < 16; k++) b_line[32*k +: 32] = $urandom();
    exp_q.push_back(b_line[511:480]);
    b_mem_rdata = b_line; b_ack = 1'b1;
    @(negedge clk);
    b_ack = 1'b0;
    check("t6_enable_after_ack", 64'(b_en), 64'h0);
    n = 0;
    while (b_stall && n < 50) begin @(negedge clk); n++; end
    check("t6_stall_cycles", 64'(n), 64'd1);
    check("t6_rdata", 64'(b_rdata), 64'(exp_q.pop_front()));
    exp_q.push_back(b_line[31:0]);
    b_addr = 32'h1_0FC0;
    #1;
    check("t6_word0_hit", 64'(b_stall), 64'h0);
    check("t6_word0_rdata", 64'(b_rdata), 64'(exp_q.pop_front()));
    @(negedge clk);
    b_rd = 1'b0;

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
